// File: rtl/rega_controller.sv
// rega_controller: irrigation control stage ahead of the MM:SS timer.
// Turns a duration into BCD, presets the timer, then paces and waters.
module rega_controller #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SCAN_DIV    = 50_000,
    parameter int unsigned LOAD_CYCLES = 2,
    parameter logic [11:0] DUR0        = 12'd30,
    parameter logic [11:0] DUR1        = 12'd75,
    parameter logic [11:0] DUR2        = 12'd300,
    parameter logic [11:0] DUR3        = 12'd900
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       soil_dry,
    input  logic [1:0] dur_sel,
    input  logic       timer_zero,
    output logic       new_clock,
    output logic [1:0] seletor,
    output logic [3:0] preset_us,
    output logic [3:0] preset_ds,
    output logic [3:0] preset_um,
    output logic [3:0] preset_dm,
    output logic [3:0] clear_us,
    output logic [3:0] clear_ds,
    output logic [3:0] clear_um,
    output logic [3:0] clear_dm,
    output logic       valve,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_HZ / 2);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
    localparam logic [11:0]   SECS_MAX  = 12'd3599;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        LOAD,
        ARM,
        WATER,
        PAUSE,
        DONE,
        ABORT_CLR
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic [SW-1:0] scanCnt;
    logic [LW-1:0] loadCnt;
    logic          loadEnd;
    logic [1:0]    selQ;
    logic          convFirst;
    logic [11:0]   secs;
    logic [11:0]   durPick;
    logic [11:0]   durSat;
    logic [3:0]    dm;
    logic [3:0]    um;
    logic [3:0]    ds;

    assign loadEnd = (loadCnt == LOAD_LAST);

    // Pick the duration captured at start and clamp it to 59:59.
    always_comb begin
        durPick = DUR0;
        unique case (selQ)
            2'd0: durPick = DUR0;
            2'd1: durPick = DUR1;
            2'd2: durPick = DUR2;
            2'd3: durPick = DUR3;
        endcase
        durSat = (durPick > SECS_MAX) ? SECS_MAX : durPick;
    end

    // Next state; abort overrides everything except IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start && soil_dry)
                    stateNext = CONVERT;
            end
            CONVERT: begin
                if (!convFirst && secs < 12'd10)
                    stateNext = LOAD;
            end
            LOAD: begin
                if (loadEnd)
                    stateNext = ARM;
            end
            ARM: begin
                stateNext = timer_zero ? DONE : WATER;
            end
            WATER: begin
                if (timer_zero)
                    stateNext = DONE;
                else if (!soil_dry)
                    stateNext = PAUSE;
            end
            PAUSE: begin
                if (timer_zero)
                    stateNext = DONE;
                else if (soil_dry)
                    stateNext = WATER;
            end
            DONE: begin
                stateNext = IDLE;
            end
            ABORT_CLR: begin
                if (loadEnd)
                    stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (abort && state != IDLE && state != ABORT_CLR)
            stateNext = ABORT_CLR;
    end

    // Prescaler advances only during WATER and restarts in ARM.
    always_comb begin
        cntNext = cnt;
        if (state == ARM)
            cntNext = '0;
        else if (state == WATER)
            cntNext = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end

    // FSM state plus every registered output, derived from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            loadCnt   <= '0;
            busy      <= 1'b0;
            valve     <= 1'b0;
            done      <= 1'b0;
            new_clock <= 1'b0;
            preset_dm <= 4'h0;
            preset_um <= 4'h0;
            preset_ds <= 4'h0;
            preset_us <= 4'h0;
            clear_dm  <= 4'h0;
            clear_um  <= 4'h0;
            clear_ds  <= 4'h0;
            clear_us  <= 4'h0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            busy      <= (stateNext != IDLE);
            valve     <= (stateNext == WATER);
            done      <= (stateNext == DONE);
            new_clock <= (stateNext == WATER || stateNext == PAUSE)
                         && (cntNext >= CNT_HALF);
            if (stateNext == state
                && (state == LOAD || state == ABORT_CLR))
                loadCnt <= loadCnt + 1'b1;
            else
                loadCnt <= '0;
            case (stateNext)
                LOAD: begin
                    preset_dm <= dm;
                    preset_um <= um;
                    preset_ds <= ds;
                    preset_us <= secs[3:0];
                    clear_dm  <= ~dm;
                    clear_um  <= ~um;
                    clear_ds  <= ~ds;
                    clear_us  <= ~secs[3:0];
                end
                ABORT_CLR: begin
                    preset_dm <= 4'h0;
                    preset_um <= 4'h0;
                    preset_ds <= 4'h0;
                    preset_us <= 4'h0;
                    clear_dm  <= 4'hF;
                    clear_um  <= 4'hF;
                    clear_ds  <= 4'hF;
                    clear_us  <= 4'hF;
                end
                default: begin
                    preset_dm <= 4'h0;
                    preset_um <= 4'h0;
                    preset_ds <= 4'h0;
                    preset_us <= 4'h0;
                    clear_dm  <= 4'h0;
                    clear_um  <= 4'h0;
                    clear_ds  <= 4'h0;
                    clear_us  <= 4'h0;
                end
            endcase
        end
    end

    // Seconds to BCD by repeated subtraction, one step per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            selQ      <= 2'd0;
            convFirst <= 1'b0;
            secs      <= 12'd0;
            dm        <= 4'd0;
            um        <= 4'd0;
            ds        <= 4'd0;
        end else if (state == IDLE && stateNext == CONVERT) begin
            selQ      <= dur_sel;
            convFirst <= 1'b1;
            dm        <= 4'd0;
            um        <= 4'd0;
            ds        <= 4'd0;
        end else if (state == CONVERT) begin
            if (convFirst) begin
                secs      <= durSat;
                convFirst <= 1'b0;
            end else if (secs >= 12'd600) begin
                secs <= secs - 12'd600;
                dm   <= dm + 4'd1;
            end else if (secs >= 12'd60) begin
                secs <= secs - 12'd60;
                um   <= um + 4'd1;
            end else if (secs >= 12'd10) begin
                secs <= secs - 12'd10;
                ds   <= ds + 4'd1;
            end
        end
    end

    // Free-running display scan, independent of the FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scanCnt <= '0;
            seletor <= 2'd0;
        end else if (scanCnt == SCAN_MAX) begin
            scanCnt <= '0;
            seletor <= seletor + 2'd1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

endmodule
